// File: rtl/term_pkg.sv
// ============================================================================
// Module   : term_pkg
// Purpose  : Shared byte codes and FSM state encoding for the text cursor engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package term_pkg;

  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } term_state_e;

endpackage

`default_nettype wire

// File: rtl/term_char_class.sv
// ============================================================================
// Module   : term_char_class
// Purpose  : Combinational classifier for received bytes (printable/CR/LF/BS).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_char_class
  import term_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_print,
  output logic       is_cr,
  output logic       is_lf,
  output logic       is_bs
);

  always_comb begin
    is_print = (data >= CH_PRINT_LO) && (data <= CH_PRINT_HI);
    is_cr    = (data == CH_CR);
    is_lf    = (data == CH_LF);
    is_bs    = (data == CH_BS);
  end

endmodule

`default_nettype wire

// File: rtl/text_cursor_ctrl.sv
// ============================================================================
// Module   : text_cursor_ctrl
// Purpose  : UART-to-char-RAM cursor engine with CR/LF/CRLF, wrap and blanking.
//            Optional backspace support when TERM_BACKSPACE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_cursor_ctrl
  import term_pkg::*;
#(
  parameter int          COLS      = 32,
  parameter int          ROWS      = 4,
  parameter int          HOME_ROW  = 1,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    clear_all,
  output logic                    rx_ready,
  output logic                    overrun,
  output logic                    wr_en,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic [$clog2(COLS)-1:0] wr_col,
  output logic [7:0]              wr_data,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [RW-1:0] HOME     = RW'(HOME_ROW);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  term_state_e   state_q, state_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic [CW-1:0] clr_col_q, clr_col_d;
  logic          last_cr_q, last_cr_d;
  logic          wr_en_q, wr_en_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          overrun_q, overrun_d;

  logic char_print, char_cr, char_lf, char_bs;

  term_char_class u_char_class (
    .data     (rx_data),
    .is_print (char_print),
    .is_cr    (char_cr),
    .is_lf    (char_lf),
    .is_bs    (char_bs)
  );

  logic          accept;
  logic          newline;
  logic          at_last_col;
  logic          line_done;
  logic          all_done;
  logic          bs_take;
  logic [RW-1:0] row_next;

`ifdef TERM_BACKSPACE_EN
  assign bs_take = char_bs && (cur_col_q != '0);
`else
  logic unused_bs;
  assign unused_bs = char_bs;
  assign bs_take   = 1'b0;
`endif

  // clear_all outranks rx_valid, so a colliding byte is neither accepted nor an overrun
  assign accept      = rx_valid && (state_q == IDLE) && !clear_all;
  assign newline     = char_cr || (char_lf && !last_cr_q);
  assign at_last_col = (cur_col_q == LAST_COL);
  assign line_done   = (clr_col_q == LAST_COL);
  assign all_done    = line_done && (clr_row_q == LAST_ROW);
  assign row_next    = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + RW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLR_ALL;
      cur_row_q <= HOME;
      cur_col_q <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      last_cr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      last_cr_q <= last_cr_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_all) begin
      state_d = CLR_ALL;
    end else begin
      case (state_q)
        IDLE:     if (accept && !char_print && newline) state_d = CLR_LINE;
                  else if (accept && char_print && at_last_col) state_d = CLR_LINE;
        CLR_LINE: if (line_done) state_d = IDLE;
        CLR_ALL:  if (all_done) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    last_cr_d = last_cr_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    overrun_d = rx_valid && (state_q != IDLE) && !clear_all;

    if (clear_all) begin
      cur_row_d = HOME;
      cur_col_d = '0;
      clr_row_d = '0;
      clr_col_d = '0;
      last_cr_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_cr_d = char_cr;
            if (char_print) begin
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q;
              wr_col_d  = cur_col_q;
              wr_data_d = rx_data;
              if (at_last_col) begin
                cur_col_d = '0;
                cur_row_d = row_next;
                clr_col_d = '0;
              end else begin
                cur_col_d = cur_col_q + CW'(1);
              end
            end else if (newline) begin
              cur_col_d = '0;
              cur_row_d = row_next;
              clr_col_d = '0;
            end else if (bs_take) begin
              cur_col_d = cur_col_q - CW'(1);
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q;
              wr_col_d  = cur_col_q - CW'(1);
              wr_data_d = FILL_CHAR;
            end
          end
        end
        CLR_LINE: begin
          wr_en_d   = 1'b1;
          wr_row_d  = cur_row_q;
          wr_col_d  = clr_col_q;
          wr_data_d = FILL_CHAR;
          clr_col_d = line_done ? '0 : clr_col_q + CW'(1);
        end
        CLR_ALL: begin
          wr_en_d   = 1'b1;
          wr_row_d  = clr_row_q;
          wr_col_d  = clr_col_q;
          wr_data_d = FILL_CHAR;
          if (line_done) begin
            clr_col_d = '0;
            clr_row_d = all_done ? '0 : clr_row_q + RW'(1);
          end else begin
            clr_col_d = clr_col_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready = (state_q == IDLE);
  assign overrun  = overrun_q;
  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;

endmodule

`default_nettype wire

// File: tb/tb_text_cursor_ctrl.sv
// ============================================================================
// Module   : tb_text_cursor_ctrl
// Purpose  : Directed self-checking bench for text_cursor_ctrl (COLS=32, ROWS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_text_cursor_ctrl;

  localparam int COLS = 32;
  localparam int ROWS = 4;
  localparam int RW   = 2;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clear_all;
  logic          rx_ready;
  logic          overrun;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [7:0]    wr_data;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  int vectors     = 0;
  int miscompares = 0;

  text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .HOME_ROW(1), .FILL_CHAR(8'h20)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .clear_all (clear_all),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Counts blanking writes until rx_ready returns; checks address order and fill code
  task automatic drain(input bit all, input int row, input int start_col,
                       output int nwr, output int nbad, output bit tout);
    nwr  = 0;
    nbad = 0;
    tout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rx_ready === 1'b1) begin
        tout = 1'b0;
        break;
      end
      tick();
      if (wr_en === 1'b1) begin
        int er;
        int ec;
        er = all ? nwr / COLS : row;
        ec = all ? nwr % COLS : start_col + nwr;
        if (wr_row !== er[RW-1:0] || wr_col !== ec[CW-1:0] || wr_data !== 8'h20) nbad++;
        nwr++;
      end
    end
    if (rx_ready === 1'b1) tout = 1'b0;
  endtask

  task automatic check_drain(input string name, input bit all, input int row,
                             input int start_col, input int exp_n);
    int  n;
    int  bad;
    bit  to;
    drain(all, row, start_col, n, bad, to);
    vectors++;
    if (to || n != exp_n || bad != 0) begin
      miscompares++;
      $display("FAIL %s: got writes=%0d bad=%0d timeout=%0d, want writes=%0d bad=0 timeout=0",
               name, n, bad, to, exp_n);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    clear_all = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({wr_en, overrun, rx_ready, cur_row, cur_col} !== {1'b0, 1'b0, 1'b0, 2'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got wr_en=%b ovr=%b rdy=%b cur=(%0d,%0d), want 0 0 0 (1,0)",
               wr_en, overrun, rx_ready, cur_row, cur_col);
    end
    reset = 1'b1;
    check_drain("reset_clear_all", 1'b1, 0, 0, ROWS * COLS);
    vectors++;
    if ({wr_en, cur_row, cur_col} !== {1'b1, 2'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_ready_on_last: got wr_en=%b cur=(%0d,%0d), want wr_en=1 cur=(1,0)",
               wr_en, cur_row, cur_col);
    end
  endtask

  task automatic test_print();
    send_byte(8'h41);
    vectors++;
    if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col} !==
        {1'b1, 2'd1, 5'd0, 8'h41, 2'd1, 5'd1}) begin
      miscompares++;
      $display("FAIL print_A: got wr=%b (%0d,%0d)=%h cur=(%0d,%0d), want wr=1 (1,0)=41 cur=(1,1)",
               wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
    end
    send_byte(8'h42);
    vectors++;
    if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, rx_ready} !==
        {1'b1, 2'd1, 5'd1, 8'h42, 2'd1, 5'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL print_B: got wr=%b (%0d,%0d)=%h cur=(%0d,%0d) rdy=%b, want wr=1 (1,1)=42 cur=(1,2) rdy=1",
               wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, rx_ready);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    send_byte(8'h0D);
    vectors++;
    if ({wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b0, 2'd2, 5'd0}) begin
      miscompares++;
      $display("FAIL cr_mid_line: got wr=%b rdy=%b cur=(%0d,%0d), want wr=0 rdy=0 cur=(2,0)",
               wr_en, rx_ready, cur_row, cur_col);
    end
    check_drain("clr_line_row2", 1'b0, 2, 0, COLS);
    send_byte(8'h0D);
    check_drain("clr_line_row3", 1'b0, 3, 0, COLS);
    for (int i = 0; i < COLS; i++) begin
      b = 8'h41 + 8'(i % 26);
      send_byte(b);
      vectors++;
      if ({wr_en, wr_row, wr_col, wr_data} !== {1'b1, 2'd3, 5'(i), b}) begin
        miscompares++;
        $display("FAIL wrap_byte%0d: got wr=%b (%0d,%0d)=%h, want wr=1 (3,%0d)=%h",
                 i, wr_en, wr_row, wr_col, wr_data, i, b);
      end
    end
    vectors++;
    if ({cur_row, cur_col, rx_ready} !== {2'd0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_cursor: got cur=(%0d,%0d) rdy=%b, want cur=(0,0) rdy=0",
               cur_row, cur_col, rx_ready);
    end
    check_drain("wrap_clr_row0", 1'b0, 0, 0, COLS);
  endtask

  task automatic test_crlf();
    send_byte(8'h0D);
    vectors++;
    if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL crlf_cr: got wr=%b cur=(%0d,%0d), want wr=0 cur=(1,0)", wr_en, cur_row, cur_col);
    end
    check_drain("crlf_clr_row1", 1'b0, 1, 0, COLS);
    send_byte(8'h0A);
    vectors++;
    if ({wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b1, 2'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL crlf_lf_silent: got wr=%b rdy=%b cur=(%0d,%0d), want wr=0 rdy=1 cur=(1,0)",
               wr_en, rx_ready, cur_row, cur_col);
    end
    send_byte(8'h0A);
    vectors++;
    if ({wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b0, 2'd2, 5'd0}) begin
      miscompares++;
      $display("FAIL lone_lf: got wr=%b rdy=%b cur=(%0d,%0d), want wr=0 rdy=0 cur=(2,0)",
               wr_en, rx_ready, cur_row, cur_col);
    end
    check_drain("lf_clr_row2", 1'b0, 2, 0, COLS);
    send_byte(8'h07);
    send_byte(8'h7F);
    send_byte(8'h80);
    vectors++;
    if ({wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b1, 2'd2, 5'd0}) begin
      miscompares++;
      $display("FAIL ignored_codes: got wr=%b rdy=%b cur=(%0d,%0d), want wr=0 rdy=1 cur=(2,0)",
               wr_en, rx_ready, cur_row, cur_col);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'h0D);
    send_byte(8'h5A);
    vectors++;
    if ({overrun, wr_en, wr_row, wr_col, wr_data} !== {1'b1, 1'b1, 2'd3, 5'd0, 8'h20}) begin
      miscompares++;
      $display("FAIL overrun_pulse: got ovr=%b wr=%b (%0d,%0d)=%h, want ovr=1 wr=1 (3,0)=20",
               overrun, wr_en, wr_row, wr_col, wr_data);
    end
    tick();
    vectors++;
    if ({overrun, wr_data} !== {1'b0, 8'h20}) begin
      miscompares++;
      $display("FAIL overrun_one_cycle: got ovr=%b data=%h, want ovr=0 data=20", overrun, wr_data);
    end
    check_drain("overrun_clr_rest", 1'b0, 3, 2, COLS - 2);
    send_byte(8'h51);
    rx_data   = 8'h58;
    rx_valid  = 1'b1;
    clear_all = 1'b1;
    tick();
    rx_valid  = 1'b0;
    clear_all = 1'b0;
    vectors++;
    if ({overrun, wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b0, 1'b0, 2'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL clear_collide: got ovr=%b wr=%b rdy=%b cur=(%0d,%0d), want 0 0 0 (1,0)",
               overrun, wr_en, rx_ready, cur_row, cur_col);
    end
    tick();
    vectors++;
    if ({overrun, wr_row, wr_col, wr_data} !== {1'b0, 2'd0, 5'd0, 8'h20}) begin
      miscompares++;
      $display("FAIL clear_collide_next: got ovr=%b (%0d,%0d)=%h, want ovr=0 (0,0)=20",
               overrun, wr_row, wr_col, wr_data);
    end
    repeat (9) tick();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check_drain("clear_all_restart", 1'b1, 0, 0, ROWS * COLS);
  endtask

  task automatic test_backspace();
    send_byte(8'h0D);
    check_drain("bs_setup_row2", 1'b0, 2, 0, COLS);
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    send_byte(8'h08);
`ifdef TERM_BACKSPACE_EN
    vectors++;
    if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col} !==
        {1'b1, 2'd2, 5'd4, 8'h20, 2'd2, 5'd4}) begin
      miscompares++;
      $display("FAIL bs_mid: got wr=%b (%0d,%0d)=%h cur=(%0d,%0d), want wr=1 (2,4)=20 cur=(2,4)",
               wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
    end
`else
    vectors++;
    if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd2, 5'd5}) begin
      miscompares++;
      $display("FAIL bs_ignored: got wr=%b cur=(%0d,%0d), want wr=0 cur=(2,5)",
               wr_en, cur_row, cur_col);
    end
`endif
    send_byte(8'h0D);
    check_drain("bs_setup_row3", 1'b0, 3, 0, COLS);
    send_byte(8'h08);
    vectors++;
    if ({wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b1, 2'd3, 5'd0}) begin
      miscompares++;
      $display("FAIL bs_col0: got wr=%b rdy=%b cur=(%0d,%0d), want wr=0 rdy=1 cur=(3,0)",
               wr_en, rx_ready, cur_row, cur_col);
    end
  endtask

  initial begin
    test_reset();
    test_print();
    test_wrap();
    test_crlf();
    test_overrun();
    test_backspace();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
